// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame constants, arbiter state type and round-robin pick
package spi_pkg;
  localparam int unsigned SPI_DATA_W = 12;
  localparam int unsigned SPI_FRAME_PULSES = 14;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TAIL, GAP} spi_arb_state_t;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int unsigned n);
    logic [2:0] g;
    logic hit;
    int unsigned idx;
    g = ptr;
    hit = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx -= n;
      if (i < n && !hit && req[idx[2:0]]) begin
        g = idx[2:0];
        hit = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divided SPI clock with rise/fall strobes and end-of-frame detect
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic done
);
  localparam int unsigned CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic [3:0] pcnt;
  logic term;
  assign term = en && cnt == CW'(CLK_DIV - 1);
  assign rise = term && !sclk && pcnt != 4'(SPI_FRAME_PULSES);
  assign fall = term && sclk;
  // after the last pulse, the would-be next rise instead ends the frame
  assign done = term && !sclk && pcnt == 4'(SPI_FRAME_PULSES);
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      cnt <= '0;
      sclk <= 1'b0;
      pcnt <= '0;
    end else begin
      cnt <= term ? '0 : cnt + CW'(1);
      if (rise) sclk <= 1'b1;
      if (fall) begin
        sclk <= 1'b0;
        pcnt <= pcnt + 4'd1;
      end
    end
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter sharing one LSB-first 12-bit SPI master link
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W = SPI_DATA_W,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sclk,
  output logic                       cs,
  output logic                       mosi
);
  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned GCW = $clog2(GAP_CYCLES) + 1;
  spi_arb_state_t state, state_d;
  logic [GW-1:0] ptr, pick;
  logic [DATA_W-1:0] sh;
  logic [3:0] bcnt;
  logic [GCW-1:0] gcnt;
  logic en, rise, fall, done;
  assign en = state == LEAD || state == SHIFT || state == TAIL;
  assign cs = !en;
  assign busy = state != IDLE;
  assign pick = GW'(rr_pick(8'(req), 3'(ptr), NUM_REQ));
  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .rst(rst), .en(en), .sclk(sclk), .rise(rise), .fall(fall), .done(done)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = |req ? LEAD : IDLE;
      LEAD:    state_d = fall ? SHIFT : LEAD;
      SHIFT:   state_d = fall && bcnt == 4'(DATA_W - 1) ? TAIL : SHIFT;
      TAIL:    state_d = done ? GAP : TAIL;
      GAP:     state_d = gcnt == GCW'(GAP_CYCLES - 1) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      mosi <= 1'b0;
      ack <= '0;
      grant_id <= '0;
      ptr <= '0;
      sh <= '0;
      bcnt <= '0;
      gcnt <= '0;
    end else begin
      state <= state_d;
      ack <= '0;
      if (state == IDLE && |req) begin
        grant_id <= pick;
        sh <= req_data[pick*DATA_W +: DATA_W];
        mosi <= 1'b0;
      end
      if (state == LEAD && rise) bcnt <= '0;
      // mosi only moves on falls so it is stable across every rise
      if ((state == LEAD || state == SHIFT) && fall) begin
        mosi <= state == SHIFT && bcnt == 4'(DATA_W - 1) ? 1'b0 : sh[0];
        sh <= sh >> 1;
        if (state == SHIFT) bcnt <= bcnt + 4'd1;
      end
      if (state == TAIL && done) begin
        ack[grant_id] <= 1'b1;
        ptr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + GW'(1);
        gcnt <= '0;
      end
      if (state == GAP) gcnt <= gcnt + GCW'(1);
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed checks of arbitration, framing, reset and divider corner
module tb_spi_master_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req, req2;
  logic [47:0] req_data, req_data2;
  logic [3:0] ack_v[2];
  logic busy_v[2], sclk_v[2], cs_v[2], mosi_v[2];
  logic [1:0] gid[2];
  int checks = 0;
  int errs = 0;
  int f, gb;
  int cslow[2] = '{0, 0};
  int hi_run[2] = '{0, 0};
  int last_cslow[2] = '{0, 0};
  int ridx[2] = '{0, 0};
  int last_ridx[2] = '{0, 0};
  int frames[2] = '{0, 0};
  int last_gap[2] = '{0, 0};
  int hi_bad[2] = '{0, 0};
  int mosi_bad[2] = '{0, 0};
  logic [13:0] rbits[2] = '{14'h0, 14'h0};
  logic [13:0] last_bits[2] = '{14'h0, 14'h0};
  logic [3:0] last_ack[2] = '{4'h0, 4'h0};
  logic pcs[2] = '{1'b1, 1'b1};
  logic psclk[2] = '{1'b0, 1'b0};
  logic pmosi[2] = '{1'b0, 1'b0};
  int glog[$];

  always #5 clk = ~clk;

  spi_master_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack_v[0]), .busy(busy_v[0]),
    .grant_id(gid[0]), .sclk(sclk_v[0]), .cs(cs_v[0]), .mosi(mosi_v[0])
  );
  spi_master_arbiter #(.CLK_DIV(2), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .ack(ack_v[1]), .busy(busy_v[1]),
    .grant_id(gid[1]), .sclk(sclk_v[1]), .cs(cs_v[1]), .mosi(mosi_v[1])
  );

  // slave-side view of each link, sampled mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pcs[k] && !cs_v[k]) begin
        if (k == 0) glog.push_back(int'(gid[0]));
        last_gap[k] = hi_run[k];
        cslow[k] = 0;
        ridx[k] = 0;
        rbits[k] = '0;
      end
      if (!pcs[k] && cs_v[k]) begin
        last_cslow[k] = cslow[k];
        last_bits[k] = rbits[k];
        last_ridx[k] = ridx[k];
        last_ack[k] = ack_v[k];
        frames[k]++;
        hi_run[k] = 0;
      end
      if (!cs_v[k]) cslow[k]++;
      else hi_run[k]++;
      if (cs_v[k] && (sclk_v[k] || mosi_v[k])) hi_bad[k]++;
      if (!cs_v[k] && sclk_v[k] && !psclk[k]) begin
        if (ridx[k] < 14) rbits[k][ridx[k]] = mosi_v[k];
        ridx[k]++;
      end
      if (mosi_v[k] != pmosi[k] && !(psclk[k] && !sclk_v[k])) mosi_bad[k]++;
      pcs[k] = cs_v[k];
      psclk[k] = sclk_v[k];
      pmosi[k] = mosi_v[k];
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input int k, input int target);
    int n = 0;
    while (frames[k] < target && n < 3000) begin
      step();
      n++;
    end
    chk("frame_timeout", 32'(frames[k] >= target), 32'd1);
  endtask

  task automatic wait_ridx(input int k, input int v);
    int n = 0;
    while (!(!cs_v[k] && ridx[k] >= v) && n < 3000) begin
      step();
      n++;
    end
    chk("ridx_timeout", 32'(ridx[k] >= v), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req2 = '0;
    req_data = '0;
    req_data2 = '0;
    step(3);
    chk("rst_cs", 32'(cs_v[0]), 1);
    chk("rst_sclk", 32'(sclk_v[0]), 0);
    chk("rst_mosi", 32'(mosi_v[0]), 0);
    chk("rst_busy", 32'(busy_v[0]), 0);
    chk("rst_ack", 32'(ack_v[0]), 0);
    chk("rst_gid", 32'(gid[0]), 0);
    rst = 1'b1;
    step();
    // single request from requester 1
    req_data[12 +: 12] = 12'hA5C;
    req = 4'b0010;
    step();
    chk("a_cs_fall", 32'(cs_v[0]), 0);
    chk("a_grant", 32'(gid[0]), 1);
    chk("a_busy", 32'(busy_v[0]), 1);
    f = frames[0];
    wait_frame(0, f + 1);
    req = '0;
    chk("a_word", 32'(last_bits[0][12:1]), 32'hA5C);
    chk("a_bits", 32'(last_bits[0]), 32'h14B8);
    chk("a_pulses", 32'(last_ridx[0]), 14);
    chk("a_cslow", 32'(last_cslow[0]), 116);
    chk("a_ack", 32'(last_ack[0]), 32'b0010);
    step();
    chk("a_ack_pulse", 32'(ack_v[0]), 0);
    step(6);
    chk("a_idle", 32'(busy_v[0]), 0);
    // all four requesting, pointer reset to 0
    rst = 1'b0;
    step();
    rst = 1'b1;
    gb = glog.size();
    for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = 12'(12'h100 + i);
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      f = frames[0];
      wait_frame(0, f + 1);
      chk("b_grant", 32'(glog[gb+j]), 32'(j % 4));
      chk("b_ack", 32'(last_ack[0]), 32'(1 << (j % 4)));
      chk("b_word", 32'(last_bits[0][12:1]), 32'(32'h100 + j % 4));
      if (j > 0) chk("b_gap", 32'(last_gap[0]), 3);
    end
    req = '0;
    step(6);
    // fairness: req[2] held, req[0] raised during the second frame
    rst = 1'b0;
    step();
    rst = 1'b1;
    gb = glog.size();
    req = 4'b0100;
    f = frames[0];
    wait_frame(0, f + 1);
    step(8);
    chk("c_frame2", 32'(cs_v[0]), 0);
    req = 4'b0101;
    wait_frame(0, f + 2);
    wait_frame(0, f + 3);
    chk("c_ack0", 32'(last_ack[0]), 32'b0001);
    req = 4'b0100;
    wait_frame(0, f + 4);
    req = '0;
    chk("c_g0", 32'(glog[gb]), 2);
    chk("c_g1", 32'(glog[gb+1]), 2);
    chk("c_g2", 32'(glog[gb+2]), 0);
    chk("c_g3", 32'(glog[gb+3]), 2);
    step(6);
    // reset during bit 5 of a frame
    req_data[36 +: 12] = 12'h5A5;
    req = 4'b1000;
    wait_ridx(0, 6);
    f = frames[0];
    rst = 1'b0;
    step();
    chk("d_cs", 32'(cs_v[0]), 1);
    chk("d_sclk", 32'(sclk_v[0]), 0);
    chk("d_mosi", 32'(mosi_v[0]), 0);
    chk("d_busy", 32'(busy_v[0]), 0);
    chk("d_ack", 32'(ack_v[0]), 0);
    chk("d_gid", 32'(gid[0]), 0);
    chk("d_noack", 32'(last_ack[0]), 0);
    rst = 1'b1;
    step();
    chk("d_regrant_cs", 32'(cs_v[0]), 0);
    chk("d_regrant_gid", 32'(gid[0]), 3);
    wait_frame(0, f + 2);
    req = '0;
    chk("d_word", 32'(last_bits[0][12:1]), 32'h5A5);
    chk("d_ack3", 32'(last_ack[0]), 32'b1000);
    step(6);
    // data changed and request withdrawn mid-frame
    req_data[0 +: 12] = 12'hFFF;
    req = 4'b0001;
    f = frames[0];
    wait_ridx(0, 3);
    req_data = '0;
    req = '0;
    wait_frame(0, f + 1);
    chk("e_word", 32'(last_bits[0][12:1]), 32'hFFF);
    chk("e_ack", 32'(last_ack[0]), 32'b0001);
    step(12);
    chk("e_idle_busy", 32'(busy_v[0]), 0);
    chk("e_no_refire", 32'(frames[0]), 32'(f + 1));
    // fastest divider, shortest gap
    req_data2[0 +: 12] = 12'h001;
    req2 = 4'b0001;
    f = frames[1];
    wait_frame(1, f + 1);
    req2 = '0;
    chk("f_cslow", 32'(last_cslow[1]), 58);
    chk("f_bits", 32'(last_bits[1]), 32'h0002);
    chk("f_pulses", 32'(last_ridx[1]), 14);
    chk("f_ack", 32'(last_ack[1]), 32'b0001);
    step(4);
    chk("hi_bad0", 32'(hi_bad[0]), 0);
    chk("hi_bad1", 32'(hi_bad[1]), 0);
    chk("mosi_bad0", 32'(mosi_bad[0]), 0);
    chk("mosi_bad1", 32'(mosi_bad[1]), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
